// File: rtl/priv_key_gen_pkg.sv
// Shared definitions for the private-key generator.
//   state_t      : controller state encoding (also visible on the debug port)
//   acc_width()  : accumulator / dividend width for a given key half-width and
//                  exponent width. k*f_n+1 with k <= e-1 < 2**e_WIDTH always fits.
package priv_key_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int acc_width(input int half_key_length, input int e_width);
        return 2 * half_key_length + e_width;
    endfunction

endpackage

// File: rtl/priv_key_gen_div.sv
// Serial restoring divider, one quotient bit per cycle, MSB first.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : load dividend/divisor; the first quotient bit is produced on
//               this same edge, so the full quotient takes ACC_W edges
//   dividend  : ACC_W-bit dividend
//   divisor   : e_WIDTH-bit divisor (must be non-zero)
//   quotient  : ACC_W-bit quotient, valid while done=1
//   remainder : e_WIDTH-bit remainder, valid while done=1
//   done      : no division step outstanding
module priv_key_div
    import priv_key_gen_pkg::*;
#(
    parameter int ACC_W   = 35,
    parameter int e_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ACC_W-1:0]   dividend,
    input  logic [e_WIDTH-1:0] divisor,
    output logic [ACC_W-1:0]   quotient,
    output logic [e_WIDTH-1:0] remainder,
    output logic               done
);

    localparam int CW = $clog2(ACC_W + 1);

    // dq starts as the dividend and shifts left; quotient bits enter at the LSB
    // while dividend bits leave at the MSB, so after ACC_W shifts it holds the quotient.
    logic [ACC_W-1:0]   dq;
    logic [e_WIDTH-1:0] rem;
    logic [e_WIDTH-1:0] div_q;
    logic [CW-1:0]      cnt;

    logic [e_WIDTH-1:0] src_rem;
    logic               src_bit;
    logic [e_WIDTH-1:0] src_div;
    logic [e_WIDTH:0]   trial;
    logic [e_WIDTH:0]   rem_nxt;
    logic               q_bit;

    always_comb begin
        src_rem = start ? '0 : rem;
        src_bit = start ? dividend[ACC_W-1] : dq[ACC_W-1];
        src_div = start ? divisor : div_q;
        trial   = {src_rem, src_bit};
        q_bit   = (trial >= {1'b0, src_div});
        rem_nxt = q_bit ? (trial - {1'b0, src_div}) : trial;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq    <= '0;
            rem   <= '0;
            div_q <= '0;
            cnt   <= '0;
        end else if (start) begin
            dq    <= {dividend[ACC_W-2:0], q_bit};
            rem   <= rem_nxt[e_WIDTH-1:0];
            div_q <= divisor;
            cnt   <= CW'(ACC_W - 1);
        end else if (cnt != '0) begin
            dq    <= {dq[ACC_W-2:0], q_bit};
            rem   <= rem_nxt[e_WIDTH-1:0];
            cnt   <= cnt - CW'(1);
        end
    end

    assign quotient  = dq;
    assign remainder = rem;
    assign done      = (cnt == '0);

endmodule

// File: rtl/priv_key_gen.sv
// RSA private exponent generator: finds the smallest k in 1..e-1 with
// (k*f_n+1) mod e == 0 and returns d = (k*f_n+1)/e.
//   clk, rst   : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE or DONE
//   f_n        : totient, e : public exponent, areValid : coprimality verdict
//   d          : private exponent (0 on error)
//   ready      : result valid (DONE), error : no d found (valid with ready)
//   busy       : search in progress (DIVIDE or CHECK)
//   dbg_state  : controller state, for observation only
//
// Handshake: a one-cycle start pulse seen in IDLE/DONE is accepted on that edge
// (inputs are captured then, ready falls on the same edge unless the request
// is rejected immediately). ready then stays high, with d/error stable, until
// the next accepted start. start and the data inputs are ignored while busy.
module priv_key_gen
    import priv_key_gen_pkg::*;
#(
    parameter int HALF_KEY_LENGTH = 16,
    parameter int e_WIDTH         = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [2*HALF_KEY_LENGTH-1:0] f_n,
    input  logic [e_WIDTH-1:0]           e,
    input  logic                         areValid,
    output logic [2*HALF_KEY_LENGTH-1:0] d,
    output logic                         ready,
    output logic                         error,
    output logic                         busy,
    output state_t                       dbg_state
);

    localparam int KW    = 2 * HALF_KEY_LENGTH;
    localparam int ACC_W = acc_width(HALF_KEY_LENGTH, e_WIDTH);

    state_t             state, state_nxt;
    logic [KW-1:0]      fn_q, fn_nxt;
    logic [e_WIDTH-1:0] e_q, e_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [e_WIDTH-1:0] k, k_nxt;
    logic [KW-1:0]      d_nxt;
    logic               err_nxt;

    logic               div_start;
    logic [ACC_W-1:0]   div_dividend;
    logic [e_WIDTH-1:0] div_divisor;
    logic [ACC_W-1:0]   div_quo;
    logic [e_WIDTH-1:0] div_rem;
    logic               div_done;

    priv_key_div #(
        .ACC_W   (ACC_W),
        .e_WIDTH (e_WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_comb begin
        state_nxt    = state;
        fn_nxt       = fn_q;
        e_nxt        = e_q;
        acc_nxt      = acc;
        k_nxt        = k;
        d_nxt        = d;
        err_nxt      = error;
        div_start    = 1'b0;
        div_dividend = '0;
        div_divisor  = e_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    d_nxt   = '0;
                    err_nxt = 1'b0;
                    if (!areValid || (e <= e_WIDTH'(1))) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        fn_nxt       = f_n;
                        e_nxt        = e;
                        acc_nxt      = ACC_W'(f_n) + ACC_W'(1);
                        k_nxt        = e_WIDTH'(1);
                        div_start    = 1'b1;
                        div_dividend = acc_nxt;
                        div_divisor  = e;
                        state_nxt    = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                if (div_done) state_nxt = CHECK;
            end
            CHECK: begin
                if (div_rem == '0) begin
                    d_nxt     = div_quo[KW-1:0];
                    err_nxt   = 1'b0;
                    state_nxt = DONE;
                end else if (k == e_q - e_WIDTH'(1)) begin
                    // Every k tried: e has no inverse modulo f_n.
                    d_nxt     = '0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    acc_nxt      = acc + ACC_W'(fn_q);
                    k_nxt        = k + e_WIDTH'(1);
                    div_start    = 1'b1;
                    div_dividend = acc_nxt;
                    state_nxt    = DIVIDE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            fn_q  <= '0;
            e_q   <= '0;
            acc   <= '0;
            k     <= '0;
            d     <= '0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            fn_q  <= fn_nxt;
            e_q   <= e_nxt;
            acc   <= acc_nxt;
            k     <= k_nxt;
            d     <= d_nxt;
            error <= err_nxt;
        end
    end

    assign ready     = (state == DONE);
    assign busy      = (state == DIVIDE) || (state == CHECK);
    assign dbg_state = state;

endmodule

// File: tb/tb_priv_key_gen.sv
module tb_priv_key_gen;
    import priv_key_gen_pkg::*;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [31:0] f_n = '0;
    logic [2:0]  e = '0;
    logic        are_valid = 1'b0;
    logic [31:0] d;
    logic        ready;
    logic        error;
    logic        busy;
    state_t      dbg_state;

    int checks = 0;
    int passes = 0;

    priv_key_gen #(
        .HALF_KEY_LENGTH (16),
        .e_WIDTH         (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .f_n       (f_n),
        .e         (e),
        .areValid  (are_valid),
        .d         (d),
        .ready     (ready),
        .error     (error),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Issue one request and wait (bounded) for ready; optionally throw
    // junk start pulses at the busy controller.
    task automatic run_op(input string tag, input logic [31:0] fn, input logic [2:0] ee,
                          input logic v, input bit noise, input int exp_edges,
                          input logic [31:0] exp_d, input logic exp_err);
        int edges;
        @(negedge clk);
        f_n = fn; e = ee; are_valid = v; start = 1'b1;
        edges = 0;
        while (edges < 400) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
            if (edges == 1 && exp_edges > 1) begin
                check({tag, "_accept_ready"}, ready, 0);
                check({tag, "_accept_busy"}, busy, 1);
            end
            if (noise && (edges == 5 || edges == 100)) begin
                start = 1'b1; f_n = 32'd1; e = 3'd5; are_valid = 1'b0;
            end
            if (ready) break;
        end
        start = 1'b0;
        check({tag, "_edges"}, edges, exp_edges);
        check({tag, "_d"}, d, exp_d);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        // reset state
        #2;
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_d", d, 0);
        check("rst_state", dbg_state, IDLE);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_ready", ready, 0);
        check("post_rst_state", dbg_state, IDLE);

        // 120, e=7: k=6, 721/7 = 103
        run_op("op_120_7", 32'd120, 3'd7, 1'b1, 1'b0, 217, 32'd103, 1'b0);
        repeat (4) @(negedge clk);
        check("hold_ready", ready, 1);
        check("hold_d", d, 103);

        // 40, e=3: k=2, 81/3 = 27
        run_op("op_40_3", 32'd40, 3'd3, 1'b1, 1'b0, 73, 32'd27, 1'b0);
        // 42, e=3: 43 and 85 both leave remainder 1
        run_op("op_42_3", 32'd42, 3'd3, 1'b1, 1'b0, 73, 32'd0, 1'b1);
        // rejected requests
        run_op("inval", 32'd120, 3'd7, 1'b0, 1'b0, 1, 32'd0, 1'b1);
        run_op("e_one", 32'd120, 3'd1, 1'b1, 1'b0, 1, 32'd0, 1'b1);
        // junk starts while busy must not disturb the search
        run_op("noise_120_7", 32'd120, 3'd7, 1'b1, 1'b1, 217, 32'd103, 1'b0);

        // asynchronous reset in the middle of DIVIDE
        @(negedge clk);
        f_n = 32'd40; e = 3'd3; are_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_ready", ready, 0);
        check("arst_busy", busy, 0);
        check("arst_error", error, 0);
        check("arst_d", d, 0);
        check("arst_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rel_state", dbg_state, IDLE);
        check("rel_busy", busy, 0);
        run_op("rerun_40_3", 32'd40, 3'd3, 1'b1, 1'b0, 73, 32'd27, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
